// File: rtl/wb_scoreboard.sv
`timescale 1ns/1ps
// Write-back stage: result FIFO draining into the 32x64 regfile plus a pending-write scoreboard.
// Optional decode forwarding from the FIFO head / regfile write is enabled by defining WB_BYPASS_EN.
module wb_scoreboard #(
  parameter int DEPTH  = 2,
  parameter int PEND_W = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        iss_valid,
  output logic        iss_ready,
  input  logic        iss_rd_en,
  input  logic [4:0]  iss_rd_addr,
  input  logic        rs1_en,
  input  logic [4:0]  rs1_addr,
  input  logic        rs2_en,
  input  logic [4:0]  rs2_addr,
  output logic        raw_stall,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic        in_rd_en,
  input  logic [4:0]  in_rd_addr,
  input  logic [63:0] in_rd_data,
  input  logic        hold,
  output logic        rf_rd_en,
  output logic [63:0] rf_rd_addr,
  output logic [63:0] rf_rd_data,
`ifdef WB_BYPASS_EN
  output logic        fwd1_en,
  output logic [63:0] fwd1_data,
  output logic        fwd2_en,
  output logic [63:0] fwd2_data,
`endif
  output logic [63:0] retired
);

  localparam int AW = $clog2(DEPTH);

  typedef struct packed {
    logic        rd_en;
    logic [4:0]  rd_addr;
    logic [63:0] data;
  } entry_t;

  entry_t            mem [DEPTH];
  logic [AW:0]       wr_ptr, rd_ptr;
  logic              full, empty, push, drain;
  entry_t            head;
  logic [PEND_W-1:0] cnt [32];
  logic [31:0]       inc, dec;
  logic              dec_same;
  logic              underflow;
  logic [4:0]        rf_addr;

  logic [1:0]        rs_en;
  logic [4:0]        rs_addr [2];
  logic [1:0]        stall;
  logic              live, rf_hit;
  logic [PEND_W-1:0] pend;
`ifdef WB_BYPASS_EN
  logic              head_hit;
  logic [1:0]        fwd_en;
  logic [63:0]       fwd_data [2];
`endif

  // ---------------- FIFO ----------------
  assign full     = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign empty    = (wr_ptr == rd_ptr);
  assign in_ready = !full;
  assign push     = in_valid && in_ready;
  assign drain    = !empty && !hold;
  assign head     = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push)  wr_ptr <= wr_ptr + (AW+1)'(1);
      if (drain) rd_ptr <= rd_ptr + (AW+1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr[AW-1:0]] <= {in_rd_en, in_rd_addr, in_rd_data};
  end

  // ---------------- regfile write port and retire counter ----------------
  always_ff @(posedge clk) begin
    if (reset) begin
      rf_rd_en   <= 1'b0;
      rf_addr    <= '0;
      rf_rd_data <= '0;
      retired    <= '0;
    end else begin
      rf_rd_en <= drain && head.rd_en && (head.rd_addr != '0);
      if (drain) begin
        rf_addr    <= head.rd_addr;
        rf_rd_data <= head.data;
        retired    <= retired + 64'd1;
      end
    end
  end

  assign rf_rd_addr = {59'd0, rf_addr};

  // ---------------- pending-write scoreboard ----------------
  // A draining writer of the same register frees a slot this cycle, so saturation does not block.
  assign dec_same  = drain && head.rd_en && (head.rd_addr == iss_rd_addr);
  assign iss_ready = !(iss_rd_en && (iss_rd_addr != '0) && (cnt[iss_rd_addr] == '1) && !dec_same);

  always_comb begin
    inc = '0;
    dec = '0;
    if (iss_valid && iss_ready && iss_rd_en) inc[iss_rd_addr] = 1'b1;
    if (drain && head.rd_en)                 dec[head.rd_addr] = 1'b1;
    inc[0] = 1'b0;
    dec[0] = 1'b0;
  end

  always_comb begin
    underflow = 1'b0;
    for (int unsigned r = 1; r < 32; r++) begin
      if (dec[r] && (cnt[r] == '0)) underflow = 1'b1;
    end
  end

  // cnt[0] is only ever written by reset, so it stays zero.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int unsigned r = 0; r < 32; r++) cnt[r] <= '0;
    end else begin
      for (int unsigned r = 1; r < 32; r++) begin
        if (inc[r] && !dec[r])
          cnt[r] <= cnt[r] + PEND_W'(1);
        else if (dec[r] && !inc[r] && (cnt[r] != '0))
          cnt[r] <= cnt[r] - PEND_W'(1);
      end
    end
  end

  a_no_underflow: assert property (@(posedge clk) disable iff (reset) !underflow);

  // ---------------- RAW hazard detection ----------------
  assign rs_en      = {rs2_en, rs1_en};
  assign rs_addr[0] = rs1_addr;
  assign rs_addr[1] = rs2_addr;

  always_comb begin
    stall  = '0;
    live   = 1'b0;
    rf_hit = 1'b0;
    pend   = '0;
`ifdef WB_BYPASS_EN
    head_hit = 1'b0;
    fwd_en   = '0;
    for (int unsigned i = 0; i < 2; i++) fwd_data[i] = '0;
`endif
    for (int unsigned i = 0; i < 2; i++) begin
      live   = rs_en[i] && (rs_addr[i] != '0);
      pend   = cnt[rs_addr[i]];
      rf_hit = rf_rd_en && (rf_addr == rs_addr[i]);
`ifdef WB_BYPASS_EN
      // Head may only forward when it is the sole outstanding writer of that register.
      head_hit    = !empty && head.rd_en && (head.rd_addr == rs_addr[i]) && (pend == PEND_W'(1));
      stall[i]    = live && (pend != '0) && !head_hit;
      fwd_en[i]   = live && (head_hit || ((pend == '0) && rf_hit));
      fwd_data[i] = head_hit ? head.data : rf_rd_data;
`else
      stall[i] = live && ((pend != '0) || rf_hit);
`endif
    end
  end

  assign raw_stall = |stall;

`ifdef WB_BYPASS_EN
  assign fwd1_en   = fwd_en[0];
  assign fwd1_data = fwd_data[0];
  assign fwd2_en   = fwd_en[1];
  assign fwd2_data = fwd_data[1];
`endif

endmodule

// File: tb/tb_wb_scoreboard.sv
`timescale 1ns/1ps
// Randomized scoreboard bench for wb_scoreboard: a queue-based reference model predicts
// ready/stall each cycle and the regfile writes a separate monitor expects.
module tb_wb_scoreboard;
  localparam int DEPTH  = 2;
  localparam int PEND_W = 2;
  localparam int CMAX   = (1 << PEND_W) - 1;
  localparam int NCYC   = 3000;

  logic        clk, reset;
  logic        iss_valid, iss_ready, iss_rd_en;
  logic [4:0]  iss_rd_addr;
  logic        rs1_en, rs2_en;
  logic [4:0]  rs1_addr, rs2_addr;
  logic        raw_stall;
  logic        in_valid, in_ready, in_rd_en;
  logic [4:0]  in_rd_addr;
  logic [63:0] in_rd_data;
  logic        hold;
  logic        rf_rd_en;
  logic [63:0] rf_rd_addr, rf_rd_data, retired;
`ifdef WB_BYPASS_EN
  logic        fwd1_en, fwd2_en;
  logic [63:0] fwd1_data, fwd2_data;
`endif

  wb_scoreboard #(.DEPTH(DEPTH), .PEND_W(PEND_W)) dut (
    .clk(clk), .reset(reset),
    .iss_valid(iss_valid), .iss_ready(iss_ready), .iss_rd_en(iss_rd_en), .iss_rd_addr(iss_rd_addr),
    .rs1_en(rs1_en), .rs1_addr(rs1_addr), .rs2_en(rs2_en), .rs2_addr(rs2_addr),
    .raw_stall(raw_stall),
    .in_valid(in_valid), .in_ready(in_ready), .in_rd_en(in_rd_en), .in_rd_addr(in_rd_addr),
    .in_rd_data(in_rd_data), .hold(hold),
    .rf_rd_en(rf_rd_en), .rf_rd_addr(rf_rd_addr), .rf_rd_data(rf_rd_data),
`ifdef WB_BYPASS_EN
    .fwd1_en(fwd1_en), .fwd1_data(fwd1_data), .fwd2_en(fwd2_en), .fwd2_data(fwd2_data),
`endif
    .retired(retired)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    bit        en;
    bit [4:0]  rd;
    bit [63:0] data;
  } ent_t;

  typedef struct {
    bit       en;
    bit [4:0] rd;
  } ins_t;

  ent_t            m_fifo[$];
  ins_t            m_pipe[$];
  ent_t            exp_q[$];
  int unsigned     m_cnt [32];
  longint unsigned m_retired;
  bit              m_rf_en;
  bit [4:0]        m_rf_rd;
  bit [63:0]       m_rf_data;
  bit              from_pipe;
  int              n_cmp, n_bad;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit head_is(input bit [4:0] a);
    return m_fifo.size() > 0 && m_fifo[0].en && m_fifo[0].rd == a;
  endfunction

  function automatic bit m_stall(input bit en, input bit [4:0] a);
    if (!en || a == 0) return 1'b0;
`ifdef WB_BYPASS_EN
    if (m_cnt[a] == 0) return 1'b0;
    if (m_cnt[a] == 1 && head_is(a)) return 1'b0;
    return 1'b1;
`else
    return m_cnt[a] != 0 || (m_rf_en && m_rf_rd == a);
`endif
  endfunction

`ifdef WB_BYPASS_EN
  task automatic check_fwd(input string name, input bit en, input bit [4:0] a,
                           input logic act_en, input logic [63:0] act_data);
    bit        fe;
    bit [63:0] fd;
    fe = 1'b0;
    fd = '0;
    if (en && a != 0) begin
      if (m_cnt[a] == 1 && head_is(a)) begin
        fe = 1'b1; fd = m_fifo[0].data;
      end else if (m_cnt[a] == 0 && m_rf_en && m_rf_rd == a) begin
        fe = 1'b1; fd = m_rf_data;
      end
    end
    check({name, "_en"}, 64'(act_en), 64'(fe));
    if (fe) check({name, "_data"}, act_data, fd);
  endtask
`endif

  task automatic model_clear();
    m_fifo.delete();
    m_pipe.delete();
    exp_q.delete();
    foreach (m_cnt[i]) m_cnt[i] = 0;
    m_retired = 0;
    m_rf_en   = 1'b0;
    m_rf_rd   = '0;
    m_rf_data = '0;
  endtask

  // Called right after the falling edge once inputs are driven; checks combinational
  // outputs, then advances the model to the state after the coming rising edge.
  task automatic step();
    bit   drn, exp_in_rdy, exp_iss_rdy, hit;
    ent_t h, n;
    #2;
    drn         = m_fifo.size() > 0 && !hold;
    exp_in_rdy  = m_fifo.size() < DEPTH;
    hit         = drn && head_is(iss_rd_addr);
    exp_iss_rdy = !(iss_rd_en && iss_rd_addr != 0 && m_cnt[iss_rd_addr] == CMAX && !hit);
    if (reset) begin
      model_clear();
      return;
    end
    check("in_ready", 64'(in_ready), 64'(exp_in_rdy));
    check("iss_ready", 64'(iss_ready), 64'(exp_iss_rdy));
    check("raw_stall", 64'(raw_stall), 64'(m_stall(rs1_en, rs1_addr) || m_stall(rs2_en, rs2_addr)));
`ifdef WB_BYPASS_EN
    check_fwd("fwd1", rs1_en, rs1_addr, fwd1_en, fwd1_data);
    check_fwd("fwd2", rs2_en, rs2_addr, fwd2_en, fwd2_data);
`endif
    m_rf_en = 1'b0;
    if (drn) begin
      h = m_fifo.pop_front();
      m_retired++;
      m_rf_rd   = h.rd;
      m_rf_data = h.data;
      if (h.en && h.rd != 0) begin
        m_rf_en = 1'b1;
        m_cnt[h.rd]--;
        exp_q.push_back(h);
      end
    end
    if (iss_valid && exp_iss_rdy) begin
      if (iss_rd_en && iss_rd_addr != 0) m_cnt[iss_rd_addr]++;
      m_pipe.push_back('{en: iss_rd_en, rd: iss_rd_addr});
    end
    if (in_valid && exp_in_rdy) begin
      n.en = in_rd_en; n.rd = in_rd_addr; n.data = in_rd_data;
      m_fifo.push_back(n);
      if (from_pipe) void'(m_pipe.pop_front());
    end
  endtask

  // Monitor: every cycle, the write predicted for this edge (if any) must appear.
  ent_t e;
  always begin
    @(posedge clk);
    #1;
    check("rf_rd_en", 64'(rf_rd_en), 64'(exp_q.size() > 0));
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      if (rf_rd_en) begin
        check("rf_rd_addr", rf_rd_addr, 64'(e.rd));
        check("rf_rd_data", rf_rd_data, e.data);
      end
    end
    check("retired", retired, m_retired);
  end

  int unsigned hpct;

  initial begin
    n_cmp = 0;
    n_bad = 0;
    model_clear();
    reset = 1'b1; hold = 1'b0;
    iss_valid = 1'b0; iss_rd_en = 1'b0; iss_rd_addr = '0;
    rs1_en = 1'b0; rs1_addr = '0; rs2_en = 1'b0; rs2_addr = '0;
    in_valid = 1'b0; in_rd_en = 1'b0; in_rd_addr = '0; in_rd_data = '0;
    from_pipe = 1'b0;
    repeat (2) @(negedge clk);
    rs1_en = 1'b1; rs1_addr = 5'd9;
    #1;
    check("reset_rf_rd_addr", rf_rd_addr, 64'd0);
    check("reset_rf_rd_data", rf_rd_data, 64'd0);
    check("reset_in_ready", 64'(in_ready), 64'd1);
    check("reset_raw_stall", 64'(raw_stall), 64'd0);

    for (int cyc = 0; cyc < NCYC; cyc++) begin
      @(negedge clk);
      reset = (cyc == 1500) || ($urandom_range(0, 399) == 0);
      case ((cyc / 500) % 3)
        0:       hpct = 60;
        1:       hpct = 10;
        default: hpct = 0;
      endcase
      hold        = $urandom_range(0, 99) < hpct;
      iss_valid   = (m_pipe.size() < 6) && ($urandom_range(0, 99) < 60);
      iss_rd_en   = $urandom_range(0, 99) < 85;
      iss_rd_addr = 5'($urandom_range(0, 7));
      rs1_en      = 1'($urandom_range(0, 1));
      rs1_addr    = 5'($urandom_range(0, 7));
      rs2_en      = 1'($urandom_range(0, 1));
      rs2_addr    = 5'($urandom_range(0, 7));
      from_pipe   = 1'b0;
      if (m_pipe.size() > 0 && $urandom_range(0, 99) < 55) begin
        in_valid   = 1'b1;
        in_rd_en   = m_pipe[0].en;
        in_rd_addr = m_pipe[0].rd;
        from_pipe  = 1'b1;
      end else begin
        in_valid   = $urandom_range(0, 99) < 5;
        in_rd_en   = 1'b0;
        in_rd_addr = 5'($urandom_range(0, 31));
      end
      in_rd_data = {$urandom, $urandom};
      step();
    end

    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      reset = 1'b0; hold = 1'b0; iss_valid = 1'b0; in_valid = 1'b0; from_pipe = 1'b0;
      step();
    end
    @(negedge clk);
    check("leftover_writes", 64'(exp_q.size()), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
